// File: rtl/uart_transmitter.sv
// uart_transmitter: 16x-oversampled UART transmitter popping a FWFT FIFO.
// config_i = {data_width[1:0], parity_mode[1:0], stop_bits[1:0]}; option UART_TX_BREAK_EN.
module uart_transmitter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       baud_rt_tick_i,
  input  logic [7:0] data_tx_i,
  input  logic       tx_fifo_empty_i,
  input  logic [5:0] config_i,
`ifdef UART_TX_BREAK_EN
  input  logic       break_i,
`endif
  output logic       tx_fifo_read_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK, BRK_REL
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`endif

  state_t     state;
  logic [7:0] data_q;
  logic [1:0] width_q;
  logic [1:0] par_q;
  logic [1:0] stop_q;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic       tx_q;
  logic       done_q;
  logic [7:0] mask;
  logic [2:0] last_idx;
  logic       last_tick;
  logic       par_en;
  logic       par_bit;
  logic       brk_req;

`ifdef UART_TX_BREAK_EN
  assign brk_req = break_i;
`else
  assign brk_req = 1'b0;
`endif

  assign last_tick = baud_rt_tick_i && (tick_cnt == 4'd15);
  assign last_idx  = {1'b1, width_q};
  assign par_en    = par_q[0] ^ par_q[1];

  // Keep only the N transmitted bits for the parity calculation
  always_comb begin
    mask = 8'hff;
    unique case (width_q)
      2'b00:   mask = 8'h1f;
      2'b01:   mask = 8'h3f;
      2'b10:   mask = 8'h7f;
      default: mask = 8'hff;
    endcase
  end

  assign par_bit = (^(data_q & mask)) ^ par_q[1];

  assign tx_fifo_read_o = !rst_i && !brk_req &&
                          !tx_fifo_empty_i && (state == IDLE);
  assign busy_o    = (state != IDLE);
  assign tx_o      = tx_q;
  assign tx_done_o = done_q;

  // Frame FSM; the line register follows the state one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      tick_cnt <= 4'd0;
      bit_idx  <= 3'd0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      data_q   <= 8'd0;
      width_q  <= 2'd0;
      par_q    <= 2'd0;
      stop_q   <= 2'd0;
    end else begin
      done_q <= 1'b0;
      if (baud_rt_tick_i)
        tick_cnt <= tick_cnt + 4'd1;
      unique case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          tick_cnt <= 4'd0;
          bit_idx  <= 3'd0;
          if (brk_req) begin
`ifdef UART_TX_BREAK_EN
            state <= BRK;
`endif
          end else if (!tx_fifo_empty_i) begin
            data_q  <= data_tx_i;
            width_q <= config_i[5:4];
            par_q   <= config_i[3:2];
            stop_q  <= config_i[1:0];
            state   <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (last_tick)
            state <= DATA;
        end
        DATA: begin
          tx_q <= data_q[bit_idx];
          if (last_tick) begin
            if (bit_idx == last_idx) begin
              bit_idx <= 3'd0;
              state   <= par_en ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          tx_q <= par_bit;
          if (last_tick)
            state <= STOP;
        end
        STOP: begin
          tx_q <= 1'b1;
          if (last_tick) begin
            if (stop_q == 2'b01 && bit_idx == 3'd0) begin
              bit_idx <= 3'd1;
            end else begin
              bit_idx <= 3'd0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BRK: begin
          tx_q     <= 1'b0;
          tick_cnt <= 4'd0;
          if (!break_i)
            state <= BRK_REL;
        end
        BRK_REL: begin
          tx_q <= 1'b1;
          if (last_tick)
            state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of uart_transmitter frames.
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] data_tx = 8'h00;
  logic       empty = 1'b1;
  logic [5:0] config_i = 6'b110000;
  logic       read_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;
`ifdef UART_TX_BREAK_EN
  logic       break_i = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [7:0] q[$];
  int fifo_popped = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  int gap_low = 0;
  int pop_at_done = 0;
  logic prev_pop = 1'b0;
  logic [1:0] tph = 2'd0;

  always #5 clk = ~clk;

  uart_transmitter dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .baud_rt_tick_i  (tick),
    .data_tx_i       (data_tx),
    .tx_fifo_empty_i (empty),
    .config_i        (config_i),
`ifdef UART_TX_BREAK_EN
    .break_i         (break_i),
`endif
    .tx_fifo_read_o  (read_o),
    .tx_o            (tx_o),
    .busy_o          (busy_o),
    .tx_done_o       (done_o)
  );

  // tick every 4 clocks and FWFT FIFO model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick = (tph == 2'd3);
      tph  = tph + 2'd1;
      while (fifo_popped < pop_cnt) begin
        if (q.size() > 0)
          void'(q.pop_front());
        fifo_popped++;
      end
      empty   = (q.size() == 0);
      data_tx = empty ? 8'h00 : q[0];
    end
  end

  // event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (read_o) begin
        pop_cnt++;
        if (empty || busy_o) viol++;
        if (!tx_o) gap_low++;
        if (done_o) pop_at_done++;
      end
      if (prev_pop && !tx_o) gap_low++;
      prev_pop = read_o;
      if (done_o) done_cnt++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_low(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_done(input int target, input int max);
    for (int i = 0; i < max; i++) begin
      if (done_cnt >= target) return;
      @(negedge clk);
    end
  endtask

  task automatic sample_frame(input int nbits,
                              input int chg_at,
                              input logic [5:0] chg_cfg,
                              output logic [11:0] got,
                              output bit done_ok);
    bit ok;
    int d0;
    got = '0;
    done_ok = 1'b0;
    wait_low(400, ok);
    if (!ok) begin
      got = 12'hfff;
      return;
    end
    d0 = done_cnt;
    repeat (31) @(negedge clk);
    got[0] = tx_o;
    for (int i = 1; i < nbits; i++) begin
      if (i == chg_at) config_i = chg_cfg;
      repeat (64) @(negedge clk);
      got[i] = tx_o;
    end
    if (done_cnt != d0) return;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_cnt == d0 + 1) begin
        done_ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit ok;
    bit dok;
    int len0;
    int len1;
    int p0;
    int pd0;
    int d0;
    int bad;
    int n;
    logic [11:0] got;
    logic [7:0] rest;

    // reset with FIFO non-empty: no pop, idle outputs
    config_i = 6'b110000;
    q.push_back(8'hA5);
    repeat (4) @(negedge clk);
    check("rst_tx", tx_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_read", read_o, 0);
    @(posedge clk); #1 rst_i = 1'b0;

    // 8N1 0xA5
    wait_low(100, ok);
    check("a5_start_seen", ok, 1);
    len0 = 0;
    while (tx_o === 1'b0 && len0 < 200) begin
      len0++;
      @(negedge clk);
    end
    len1 = 0;
    while (tx_o === 1'b1 && len1 < 200) begin
      len1++;
      @(negedge clk);
    end
    check("a5_start_len", (len0 >= 61 && len0 <= 64), 1);
    check("a5_bit0_len", len1, 64);
    rest = '0;
    repeat (31) @(negedge clk);
    rest[0] = tx_o;
    for (int i = 1; i < 8; i++) begin
      repeat (64) @(negedge clk);
      rest[i] = tx_o;
    end
    check("a5_bits_d1_stop", rest, 8'b11010010);
    check("a5_no_done_yet", done_cnt, 0);
    wait_done(1, 40);
    check("a5_done", done_cnt, 1);
    check("a5_pops", pop_cnt, 1);

    // 7E2 0x83
    config_i = 6'b100101;
    q.push_back(8'h83);
    sample_frame(11, 99, 6'b000000, got, dok);
    check("7e2_bits", got, 12'b011000000110);
    check("7e2_done", dok, 1);

    // 5O1 0x1F, config moved to 8N1 mid-frame
    config_i = 6'b001000;
    q.push_back(8'h1F);
    sample_frame(8, 3, 6'b110000, got, dok);
    check("5o1_bits", got, 12'b000010111110);
    check("5o1_done", dok, 1);

    // three queued words, 8N1
    p0 = pop_cnt;
    pd0 = pop_at_done;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h3C);
    sample_frame(10, 99, 6'b110000, got, dok);
    check("fifo_w0", got, 12'b001000000000);
    check("fifo_w0_done", dok, 1);
    sample_frame(10, 99, 6'b110000, got, dok);
    check("fifo_w1", got, 12'b001111111110);
    check("fifo_w1_done", dok, 1);
    sample_frame(10, 99, 6'b110000, got, dok);
    check("fifo_w2", got, 12'b001001111000);
    check("fifo_w2_done", dok, 1);
    repeat (200) @(negedge clk);
    check("fifo_pops", pop_cnt - p0, 3);
    check("fifo_pop_at_done", pop_at_done - pd0, 2);
    check("gap_line_high", gap_low, 0);

    // reset during data bit 3 of 0x5A
    q.push_back(8'h5A);
    wait_low(400, ok);
    check("rst_frame_seen", ok, 1);
    repeat (31 + 256) @(negedge clk);
    check("rst_mid_busy", busy_o, 1);
    check("rst_mid_bit3", tx_o, 1);
    d0 = done_cnt;
    @(posedge clk); #1 rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_abort_tx", tx_o, 1);
    check("rst_abort_busy", busy_o, 0);
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (100) @(negedge clk);
    check("rst_no_done", done_cnt, d0);
    q.push_back(8'h5A);
    sample_frame(10, 99, 6'b110000, got, dok);
    check("rst_new_frame", got, 12'b001010110100);
    check("rst_new_done", dok, 1);

`ifdef UART_TX_BREAK_EN
    // break held 500 clocks with data waiting
    @(posedge clk); #1 break_i = 1'b1;
    q.push_back(8'h11);
    p0 = pop_cnt;
    repeat (3) @(negedge clk);
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx_o !== 1'b0 || busy_o !== 1'b1) bad++;
    end
    check("brk_line_low", bad, 0);
    check("brk_no_pop", pop_cnt, p0);
    @(posedge clk); #1 break_i = 1'b0;
    n = 0;
    bad = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (read_o) break;
      if (n >= 3 && tx_o !== 1'b1) bad++;
    end
    check("brk_rel_high", bad, 0);
    check("brk_rel_len", (n >= 60 && n <= 70), 1);
    d0 = done_cnt;
    wait_done(d0 + 1, 1000);
    check("brk_frame_done", done_cnt, d0 + 1);
`endif

    check("read_rules", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
